// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter shared by the I-cache fill path and the D-cache fill/write-back path.
// Optional macro MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise D-cache has fixed priority.
module mem_arbiter #(
    parameter int ADDR_BITS = 32,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ic_req_valid_in,
    input  logic [ADDR_BITS-1:0] ic_req_addr_in,
    output logic                 ic_req_ready_out,
    output logic                 ic_resp_valid_out,
    output logic [LINE_BITS-1:0] ic_resp_data_out,
    input  logic                 dc_req_valid_in,
    input  logic                 dc_req_write_in,
    input  logic [ADDR_BITS-1:0] dc_req_addr_in,
    input  logic [LINE_BITS-1:0] dc_req_data_in,
    output logic                 dc_req_ready_out,
    output logic                 dc_resp_valid_out,
    output logic [LINE_BITS-1:0] dc_resp_data_out,
    output logic                 mem_req_valid_out,
    output logic                 mem_req_write_out,
    output logic [ADDR_BITS-1:0] mem_req_addr_out,
    output logic [LINE_BITS-1:0] mem_req_data_out,
    input  logic                 mem_req_ready_in,
    input  logic                 mem_resp_valid_in,
    input  logic [LINE_BITS-1:0] mem_resp_data_in,
    output logic                 busy_out
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t               r_state;
    logic                 r_owner;      // 1 = D-cache owns the transaction
    logic                 r_write;
    logic [ADDR_BITS-1:0] r_addr;
    logic [LINE_BITS-1:0] r_data;
    logic                 r_mem_valid;
    logic                 r_busy;
    logic                 r_ic_resp_valid;
    logic                 r_dc_resp_valid;
    logic [LINE_BITS-1:0] r_ic_resp_data;
    logic [LINE_BITS-1:0] r_dc_resp_data;

    logic w_idle;
    logic w_dc_pref;
    logic w_grant_dc;
    logic w_grant_ic;

`ifdef MEM_ARB_RR_EN
    logic r_last_owner;                 // 1 = D-cache was granted last

    assign w_dc_pref = ~r_last_owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last_owner <= 1'b0;
        else if (w_grant_dc || w_grant_ic)
            r_last_owner <= w_grant_dc;
    end
`else
    assign w_dc_pref = 1'b1;
`endif

    // Grants are combinational so the accept pulse lands in the same cycle as the request.
    assign w_idle     = rst_n && (r_state == S_IDLE);
    assign w_grant_dc = w_idle && dc_req_valid_in && (!ic_req_valid_in || w_dc_pref);
    assign w_grant_ic = w_idle && ic_req_valid_in && !w_grant_dc;

    assign ic_req_ready_out  = w_grant_ic;
    assign dc_req_ready_out  = w_grant_dc;
    assign ic_resp_valid_out = r_ic_resp_valid;
    assign ic_resp_data_out  = r_ic_resp_data;
    assign dc_resp_valid_out = r_dc_resp_valid;
    assign dc_resp_data_out  = r_dc_resp_data;
    assign mem_req_valid_out = r_mem_valid;
    assign mem_req_write_out = r_write;
    assign mem_req_addr_out  = r_addr;
    assign mem_req_data_out  = r_data;
    assign busy_out          = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_owner         <= 1'b0;
            r_write         <= 1'b0;
            r_addr          <= '0;
            r_data          <= '0;
            r_mem_valid     <= 1'b0;
            r_busy          <= 1'b0;
            r_ic_resp_valid <= 1'b0;
            r_dc_resp_valid <= 1'b0;
            r_ic_resp_data  <= '0;
            r_dc_resp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_dc || w_grant_ic) begin
                        r_owner     <= w_grant_dc;
                        r_write     <= w_grant_dc && dc_req_write_in;
                        r_addr      <= w_grant_dc ? dc_req_addr_in : ic_req_addr_in;
                        r_data      <= w_grant_dc ? dc_req_data_in : '0;
                        r_mem_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready_in) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid_in) begin
                        if (r_owner) begin
                            r_dc_resp_data  <= r_write ? '0 : mem_resp_data_in;
                            r_dc_resp_valid <= 1'b1;
                        end else begin
                            r_ic_resp_data  <= mem_resp_data_in;
                            r_ic_resp_valid <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ic_resp_valid <= 1'b0;
                    r_dc_resp_valid <= 1'b0;
                    r_busy          <= 1'b0;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single reads, write-back, contention, back-pressure and mid-WAIT reset.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ic_req_valid_in;
    logic [AW-1:0] ic_req_addr_in;
    logic          ic_req_ready_out;
    logic          ic_resp_valid_out;
    logic [LW-1:0] ic_resp_data_out;
    logic          dc_req_valid_in;
    logic          dc_req_write_in;
    logic [AW-1:0] dc_req_addr_in;
    logic [LW-1:0] dc_req_data_in;
    logic          dc_req_ready_out;
    logic          dc_resp_valid_out;
    logic [LW-1:0] dc_resp_data_out;
    logic          mem_req_valid_out;
    logic          mem_req_write_out;
    logic [AW-1:0] mem_req_addr_out;
    logic [LW-1:0] mem_req_data_out;
    logic          mem_req_ready_in;
    logic          mem_resp_valid_in;
    logic [LW-1:0] mem_resp_data_in;
    logic          busy_out;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [LW-1:0] D_A5 = {16{8'hA5}};
    localparam logic [LW-1:0] D_WB = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [LW-1:0] D_77 = {16{8'h77}};
    localparam logic [LW-1:0] D_55 = {16{8'h55}};
    localparam logic [LW-1:0] D_99 = {16{8'h99}};
    localparam logic [LW-1:0] D_EE = {16{8'hEE}};

    mem_arbiter #(.ADDR_BITS(AW), .LINE_BITS(LW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ic_req_valid_in   (ic_req_valid_in),
        .ic_req_addr_in    (ic_req_addr_in),
        .ic_req_ready_out  (ic_req_ready_out),
        .ic_resp_valid_out (ic_resp_valid_out),
        .ic_resp_data_out  (ic_resp_data_out),
        .dc_req_valid_in   (dc_req_valid_in),
        .dc_req_write_in   (dc_req_write_in),
        .dc_req_addr_in    (dc_req_addr_in),
        .dc_req_data_in    (dc_req_data_in),
        .dc_req_ready_out  (dc_req_ready_out),
        .dc_resp_valid_out (dc_resp_valid_out),
        .dc_resp_data_out  (dc_resp_data_out),
        .mem_req_valid_out (mem_req_valid_out),
        .mem_req_write_out (mem_req_write_out),
        .mem_req_addr_out  (mem_req_addr_out),
        .mem_req_data_out  (mem_req_data_out),
        .mem_req_ready_in  (mem_req_ready_in),
        .mem_resp_valid_in (mem_resp_valid_in),
        .mem_resp_data_in  (mem_resp_data_in),
        .busy_out          (busy_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called in the ISSUE cycle with memory ready; returns in the following IDLE cycle.
    task automatic serve(input logic [LW-1:0] data);
        tick();
        mem_resp_valid_in = 1'b1;
        mem_resp_data_in  = data;
        tick();
        mem_resp_valid_in = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        ic_req_valid_in = 1'b0; ic_req_addr_in = '0;
        dc_req_valid_in = 1'b0; dc_req_write_in = 1'b0; dc_req_addr_in = '0; dc_req_data_in = '0;
        mem_req_ready_in = 1'b0; mem_resp_valid_in = 1'b0; mem_resp_data_in = '0;
        tick(); tick();
        chk("rst_busy", LW'(busy_out), '0);
        chk("rst_memvalid", LW'(mem_req_valid_out), '0);
        chk("rst_icresp", LW'(ic_resp_valid_out), '0);
        rst_n = 1'b1;
        tick();

        // I-cache read
        ic_req_valid_in = 1'b1; ic_req_addr_in = 32'h0000_1000; mem_req_ready_in = 1'b1;
        #1;
        chk("ic_ready_T", LW'(ic_req_ready_out), 1);
        chk("dc_ready_T", LW'(dc_req_ready_out), 0);
        chk("busy_T", LW'(busy_out), 0);
        tick();
        ic_req_valid_in = 1'b0;
        chk("ic_memvalid", LW'(mem_req_valid_out), 1);
        chk("ic_memaddr", LW'(mem_req_addr_out), LW'(32'h1000));
        chk("ic_memwrite", LW'(mem_req_write_out), 0);
        chk("ic_memdata", mem_req_data_out, '0);
        chk("ic_busy", LW'(busy_out), 1);
        tick();
        mem_req_ready_in = 1'b0;
        chk("ic_wait_memvalid", LW'(mem_req_valid_out), 0);
        tick(); tick();
        mem_resp_valid_in = 1'b1; mem_resp_data_in = D_A5;
        chk("ic_wait_noresp", LW'(ic_resp_valid_out), 0);
        tick();
        mem_resp_valid_in = 1'b0;
        chk("ic_resp_valid", LW'(ic_resp_valid_out), 1);
        chk("ic_resp_data", ic_resp_data_out, D_A5);
        chk("ic_dc_resp_quiet", LW'(dc_resp_valid_out), 0);
        chk("ic_dc_data_quiet", dc_resp_data_out, '0);
        tick();
        chk("ic_resp_pulse_end", LW'(ic_resp_valid_out), 0);
        chk("ic_idle_busy", LW'(busy_out), 0);
        chk("ic_data_hold", ic_resp_data_out, D_A5);

        // D-cache write-back
        dc_req_valid_in = 1'b1; dc_req_write_in = 1'b1; dc_req_addr_in = 32'h2000; dc_req_data_in = D_WB;
        mem_req_ready_in = 1'b1;
        #1;
        chk("wb_ready", LW'(dc_req_ready_out), 1);
        tick();
        dc_req_valid_in = 1'b0; dc_req_write_in = 1'b0;
        chk("wb_memvalid", LW'(mem_req_valid_out), 1);
        chk("wb_memwrite", LW'(mem_req_write_out), 1);
        chk("wb_memaddr", LW'(mem_req_addr_out), LW'(32'h2000));
        chk("wb_memdata", mem_req_data_out, D_WB);
        chk("wb_busy_T1", LW'(busy_out), 1);
        tick();
        mem_resp_valid_in = 1'b1; mem_resp_data_in = D_EE;
        tick();
        mem_resp_valid_in = 1'b0;
        chk("wb_resp_valid", LW'(dc_resp_valid_out), 1);
        chk("wb_resp_zero", dc_resp_data_out, '0);
        chk("wb_ic_quiet", LW'(ic_resp_valid_out), 0);
        chk("wb_ic_data_kept", ic_resp_data_out, D_A5);
        chk("wb_busy_done", LW'(busy_out), 1);
        tick();
        chk("wb_busy_after", LW'(busy_out), 0);
        chk("wb_resp_end", LW'(dc_resp_valid_out), 0);

        // Contention: D-cache first, I-cache at R+2
        ic_req_valid_in = 1'b1; ic_req_addr_in = 32'h3000;
        dc_req_valid_in = 1'b1; dc_req_addr_in = 32'h4000; dc_req_data_in = '0;
        #1;
        chk("tie_dc_ready", LW'(dc_req_ready_out), 1);
        chk("tie_ic_ready", LW'(ic_req_ready_out), 0);
        tick();
        dc_req_valid_in = 1'b0;
        chk("tie_memaddr_dc", LW'(mem_req_addr_out), LW'(32'h4000));
        chk("tie_ic_blocked", LW'(ic_req_ready_out), 0);
        tick();
        mem_resp_valid_in = 1'b1; mem_resp_data_in = D_77;
        chk("tie_ic_blocked_wait", LW'(ic_req_ready_out), 0);
        tick();
        mem_resp_valid_in = 1'b0;
        chk("tie_dc_resp", LW'(dc_resp_valid_out), 1);
        chk("tie_dc_data", dc_resp_data_out, D_77);
        chk("tie_ic_blocked_done", LW'(ic_req_ready_out), 0);
        tick();
        #1;
        chk("tie_ic_ready_R2", LW'(ic_req_ready_out), 1);
        tick();
        ic_req_valid_in = 1'b0;
        chk("tie_memaddr_ic", LW'(mem_req_addr_out), LW'(32'h3000));
        serve(D_55);
        chk("tie_ic_data", ic_resp_data_out, D_55);

        // Back-to-back ties: round-robin alternates, fixed priority keeps D-cache
        ic_req_valid_in = 1'b1; ic_req_addr_in = 32'h5100;
        dc_req_valid_in = 1'b1; dc_req_addr_in = 32'h5200;
        #1;
        chk("tie2_dc_ready", LW'(dc_req_ready_out), 1);
        tick();
        dc_req_addr_in = 32'h5300;
        serve(D_77);
        #1;
`ifdef MEM_ARB_RR_EN
        chk("tie3_ic_ready", LW'(ic_req_ready_out), 1);
        chk("tie3_dc_ready", LW'(dc_req_ready_out), 0);
        tick();
        chk("tie3_memaddr", LW'(mem_req_addr_out), LW'(32'h5100));
`else
        chk("tie3_ic_ready", LW'(ic_req_ready_out), 0);
        chk("tie3_dc_ready", LW'(dc_req_ready_out), 1);
        tick();
        chk("tie3_memaddr", LW'(mem_req_addr_out), LW'(32'h5300));
`endif
        ic_req_valid_in = 1'b0; dc_req_valid_in = 1'b0;
        serve(D_55);

        // Memory back-pressure with a stray response during ISSUE
        ic_req_valid_in = 1'b1; ic_req_addr_in = 32'h6000; mem_req_ready_in = 1'b0;
        tick();
        ic_req_valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_resp_valid_in = (i == 2);
            mem_resp_data_in  = D_EE;
            chk("bp_valid", LW'(mem_req_valid_out), 1);
            chk("bp_addr", LW'(mem_req_addr_out), LW'(32'h6000));
            chk("bp_data", mem_req_data_out, '0);
            tick();
        end
        mem_resp_valid_in = 1'b0;
        mem_req_ready_in  = 1'b1;
        chk("bp_still_valid", LW'(mem_req_valid_out), 1);
        chk("bp_no_resp", LW'(ic_resp_valid_out), 0);
        tick();
        mem_req_ready_in = 1'b0;
        chk("bp_wait_memvalid", LW'(mem_req_valid_out), 0);
        chk("bp_wait_no_resp", LW'(ic_resp_valid_out), 0);
        mem_resp_valid_in = 1'b1; mem_resp_data_in = D_99;
        tick();
        mem_resp_valid_in = 1'b0;
        chk("bp_resp_valid", LW'(ic_resp_valid_out), 1);
        chk("bp_resp_data", ic_resp_data_out, D_99);
        tick();

        // Reset during WAIT
        dc_req_valid_in = 1'b1; dc_req_write_in = 1'b0; dc_req_addr_in = 32'h7000;
        mem_req_ready_in = 1'b1;
        tick();
        dc_req_valid_in = 1'b0;
        tick();
        mem_req_ready_in = 1'b0;
        chk("rw_busy_wait", LW'(busy_out), 1);
        rst_n = 1'b0;
        #1;
        chk("rw_busy", LW'(busy_out), 0);
        chk("rw_memaddr", LW'(mem_req_addr_out), '0);
        chk("rw_icdata", ic_resp_data_out, '0);
        chk("rw_dcdata", dc_resp_data_out, '0);
        tick();
        rst_n = 1'b1;
        mem_resp_valid_in = 1'b1; mem_resp_data_in = D_EE;
        tick();
        mem_resp_valid_in = 1'b0;
        chk("rw_no_dcresp", LW'(dc_resp_valid_out), 0);
        chk("rw_no_icresp", LW'(ic_resp_valid_out), 0);
        chk("rw_idle_busy", LW'(busy_out), 0);
        tick();
        chk("rw_dcdata_after", dc_resp_data_out, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
